// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch (IF), load/store (LS) and memory channels around mem_arbiter.
// The slave modport is the arbiter's view; master is the clients-plus-memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_flush;
  logic              if_resp_valid;
  logic [31:0]       if_resp_inst;

  logic              ls_req_valid;
  logic              ls_req_wen;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic [MASK_W-1:0] ls_req_wmask;
  logic              ls_req_ready;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] ls_resp_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_resp_valid, if_resp_inst,
    input  ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask,
    output ls_req_ready, ls_resp_valid, ls_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_resp_valid, if_resp_inst,
    output ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask,
    input  ls_req_ready, ls_resp_valid, ls_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (IF/LS) arbiter in front of a single-outstanding memory port.
// Round-robin on conflict; the IF response can be dropped by if_flush mid-flight.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic              last_ls_q, last_ls_d;
  logic              drop_q, drop_d;
  logic              is_ls_q, is_ls_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              ls_resp_valid_q, ls_resp_valid_d;
  logic              if_resp_valid_q, if_resp_valid_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic [31:0]       if_inst_q, if_inst_d;

  logic grant_ls;
  logic accept;
  logic resp_done;

  // LS wins unless IF is also valid and LS won last time; with nobody valid LS holds ready.
  assign grant_ls  = !bus.if_req_valid || (bus.ls_req_valid && !last_ls_q);
  assign accept    = (state_q == IDLE) && (grant_ls ? bus.ls_req_valid : bus.if_req_valid);
  assign resp_done = (state_q == WAIT) && bus.mem_resp_valid;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)             state_d = REQ;
      REQ:     if (bus.mem_req_ready)  state_d = WAIT;
      WAIT:    if (bus.mem_resp_valid) state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != IDLE);
    bus.mem_req_valid = (state_q == REQ);
    bus.ls_req_ready  = (state_q == IDLE) && grant_ls;
    bus.if_req_ready  = (state_q == IDLE) && !grant_ls;
  end

  // NOTE: every next-state signal gets its hold value first, so no path infers a latch.
  always_comb begin
    last_ls_d = last_ls_q;
    is_ls_d   = is_ls_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    drop_d    = drop_q;

    if (accept) begin
      last_ls_d = grant_ls;
      is_ls_d   = grant_ls;
      addr_d    = grant_ls ? bus.ls_req_addr : bus.if_req_addr;
      wen_d     = grant_ls && bus.ls_req_wen;
      wdata_d   = grant_ls ? bus.ls_req_wdata : '0;
      wmask_d   = grant_ls ? bus.ls_req_wmask : '0;
    end

    if (state_q == IDLE || resp_done) drop_d = 1'b0;
    else if (!is_ls_q && bus.if_flush) drop_d = 1'b1;

    ls_resp_valid_d = resp_done && is_ls_q;
    if_resp_valid_d = resp_done && !is_ls_q && !drop_q && !bus.if_flush;
    ls_rdata_d      = ls_resp_valid_d ? bus.mem_resp_rdata : ls_rdata_q;
    if_inst_d       = if_inst_q;
    if (if_resp_valid_d)
      if_inst_d = addr_q[2] ? bus.mem_resp_rdata[63:32] : bus.mem_resp_rdata[31:0];
  end

  // NOTE: all datapath flops are plain registers (no memory array), so all take a reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ls_q       <= 1'b0;
      drop_q          <= 1'b0;
      is_ls_q         <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      ls_resp_valid_q <= 1'b0;
      if_resp_valid_q <= 1'b0;
      ls_rdata_q      <= '0;
      if_inst_q       <= '0;
    end else begin
      last_ls_q       <= last_ls_d;
      drop_q          <= drop_d;
      is_ls_q         <= is_ls_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      if_resp_valid_q <= if_resp_valid_d;
      ls_rdata_q      <= ls_rdata_d;
      if_inst_q       <= if_inst_d;
    end
  end

  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wmask = wmask_q;
  assign bus.ls_resp_valid = ls_resp_valid_q;
  assign bus.ls_resp_rdata = ls_rdata_q;
  assign bus.if_resp_valid = if_resp_valid_q;
  assign bus.if_resp_inst  = if_inst_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions against a
// 1-cycle memory, plus hand sequences for arbitration, stalls, flush and reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ls;
    bit          wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    bit          flush_wait;
    bit          flush_resp;
    bit          exp_pulse;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  int total = 0;
  int bad   = 0;
  int ls_pulses = 0;
  int if_pulses = 0;
  int hs_cnt    = 0;
  logic [63:0] exp_ls;
  logic [31:0] exp_inst;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.ls_resp_valid) ls_pulses++;
      if (bus.if_resp_valid) if_pulses++;
      if (bus.mem_req_valid && bus.mem_req_ready) hs_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid   = 1'b0;
    bus.if_req_addr    = '0;
    bus.if_flush       = 1'b0;
    bus.ls_req_valid   = 1'b0;
    bus.ls_req_wen     = 1'b0;
    bus.ls_req_addr    = '0;
    bus.ls_req_wdata   = '0;
    bus.ls_req_wmask   = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_ls   = '0;
    exp_inst = '0;
    tick();
  endtask

  // One transaction, entered and left in IDLE at posedge+1; memory grants at once and answers next cycle.
  task automatic do_txn(input vec_t v);
    bus.ls_req_valid = v.is_ls;
    bus.if_req_valid = !v.is_ls;
    bus.ls_req_wen   = v.wen;
    bus.ls_req_addr  = v.addr;
    bus.if_req_addr  = v.addr;
    bus.ls_req_wdata = v.wdata;
    bus.ls_req_wmask = v.wmask;
    #1;
    if (v.is_ls) check("ls_req_ready", bus.ls_req_ready, 1);
    else         check("if_req_ready", bus.if_req_ready, 1);
    tick();
    bus.ls_req_valid = 1'b0;
    bus.if_req_valid = 1'b0;
    bus.ls_req_addr  = '1;
    bus.if_req_addr  = '1;
    bus.ls_req_wdata = '1;
    bus.ls_req_wmask = '1;
    bus.ls_req_wen   = 1'b1;
    #1;
    check("req_valid", bus.mem_req_valid, 1);
    check("req_addr", bus.mem_req_addr, v.addr);
    check("req_wen", bus.mem_req_wen, v.is_ls ? v.wen : 1'b0);
    check("req_wmask", bus.mem_req_wmask, v.is_ls ? v.wmask : 8'h00);
    if (v.is_ls) check("req_wdata", bus.mem_req_wdata, v.wdata);
    check("ready_busy", {bus.if_req_ready, bus.ls_req_ready}, 0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = v.rdata;
    bus.if_flush       = v.flush_wait;
    #1;
    check("req_valid_wait", bus.mem_req_valid, 0);
    check("busy_wait", busy, 1);
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    bus.if_flush       = v.flush_resp;
    #1;
    if (v.exp_pulse) begin
      if (v.is_ls) exp_ls = v.exp_data;
      else         exp_inst = v.exp_data[31:0];
    end
    check("ls_resp_valid", bus.ls_resp_valid, v.is_ls && v.exp_pulse);
    check("if_resp_valid", bus.if_resp_valid, !v.is_ls && v.exp_pulse);
    check("busy_done", busy, 0);
    check("ls_resp_rdata", bus.ls_resp_rdata, exp_ls);
    check("if_resp_inst", bus.if_resp_inst, exp_inst);
    tick();
    bus.if_flush = 1'b0;
    #1;
    check("resp_pulse_end", {bus.if_resp_valid, bus.ls_resp_valid}, 0);
  endtask

  initial begin
    int ls0, if0, hs0;
    bit exp_grant_ls;

    //     is_ls wen addr           wdata          wmask  rdata                    fl_w fl_r pulse exp
    vecs[0] = '{1, 0, 64'h8000_0008, 64'h0,         8'h00, 64'h1122334455667788, 0, 0, 1, 64'h1122334455667788};
    vecs[1] = '{0, 0, 64'h8000_0004, 64'h0,         8'h00, 64'hAAAAAAAA00100073, 0, 0, 1, 64'hAAAAAAAA};
    vecs[2] = '{0, 0, 64'h8000_0000, 64'h0,         8'h00, 64'hAAAAAAAA00100073, 0, 0, 1, 64'h00100073};
    vecs[3] = '{1, 1, 64'h8000_0010, 64'hDEADBEEF,  8'h0F, 64'h0,                0, 0, 1, 64'h0};
    vecs[4] = '{0, 0, 64'h8000_0004, 64'h0,         8'h00, 64'h1111111122222222, 1, 0, 0, 64'h0};
    vecs[5] = '{1, 0, 64'h8000_0018, 64'h0,         8'h00, 64'hCAFEF00D12345678, 1, 0, 1, 64'hCAFEF00D12345678};
    vecs[6] = '{0, 0, 64'h8000_000C, 64'h0,         8'h00, 64'h0000006FDEADC0DE, 0, 1, 1, 64'h0000006F};

    idle_inputs();
    exp_ls   = '0;
    exp_inst = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_req_valid", bus.mem_req_valid, 0);
    check("rst_resp_valid", {bus.if_resp_valid, bus.ls_resp_valid}, 0);
    check("rst_req_fields", {bus.mem_req_wen, bus.mem_req_wmask}, 0);
    check("rst_req_addr", bus.mem_req_addr, 0);
    check("rst_ls_rdata", bus.ls_resp_rdata, 0);
    check("rst_if_inst", bus.if_resp_inst, 0);
    check("rst_ready_default", {bus.if_req_ready, bus.ls_req_ready}, 2'b01);
    do_reset();

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // Flush during IF WAIT with a late response: the drop flag alone must kill the pulse.
    if0 = if_pulses;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h8000_0020;
    tick();
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.if_flush      = 1'b1;
    tick();
    bus.if_flush       = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h12345678_9ABCDEF0;
    #1;
    check("flush_busy_wait", busy, 1);
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    check("flush_busy_fall", busy, 0);
    tick();
    check("flush_no_if_pulse", if_pulses - if0, 0);
    check("flush_inst_held", bus.if_resp_inst, exp_inst);
    do_txn('{1, 0, 64'h8000_0028, 64'h0, 8'h00, 64'h0123456789ABCDEF, 0, 0, 1, 64'h0123456789ABCDEF});

    // Memory stalls an LS store for 5 cycles.
    ls0 = ls_pulses;
    hs0 = hs_cnt;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_wen   = 1'b1;
    bus.ls_req_addr  = 64'h8000_0030;
    bus.ls_req_wdata = 64'hDEADBEEF;
    bus.ls_req_wmask = 8'h0F;
    tick();
    bus.ls_req_valid = 1'b0;
    bus.ls_req_addr  = '0;
    bus.ls_req_wdata = '0;
    bus.ls_req_wmask = '0;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", bus.mem_req_valid, 1);
      check("stall_fields", {bus.mem_req_wen, bus.mem_req_wmask, bus.mem_req_wdata},
            {1'b1, 8'h0F, 64'hDEADBEEF});
      check("stall_addr", bus.mem_req_addr, 64'h8000_0030);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h55;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("stall_resp_data", bus.ls_resp_rdata, 64'h55);
    tick();
    tick();
    check("stall_one_handshake", hs_cnt - hs0, 1);
    check("stall_one_pulse", ls_pulses - ls0, 1);

    // Reset asserted while waiting for memory.
    ls0 = ls_pulses;
    if0 = if_pulses;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 64'h40;
    tick();
    bus.ls_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_req_valid", bus.mem_req_valid, 0);
    check("midrst_req_addr", bus.mem_req_addr, 0);
    check("midrst_rdata", bus.ls_resp_rdata, 0);
    check("midrst_inst", bus.if_resp_inst, 0);
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    rst = 1'b1;
    exp_ls   = '0;
    exp_inst = '0;
    repeat (3) tick();
    check("midrst_no_pulse", (ls_pulses - ls0) + (if_pulses - if0), 0);
    check("midrst_idle", busy, 0);
    do_txn(vecs[1]);

    // Both requesters valid back-to-back after reset: LS, IF, LS, IF.
    do_reset();
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 64'h1000;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h2000;
    exp_grant_ls = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", {bus.if_req_ready, bus.ls_req_ready}, exp_grant_ls ? 2'b01 : 2'b10);
      tick();
      check("rr_addr", bus.mem_req_addr, exp_grant_ls ? 64'h1000 : 64'h2000);
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 64'h0000_0001_0000_0002;
      tick();
      bus.mem_resp_valid = 1'b0;
      check("rr_pulse", {bus.if_resp_valid, bus.ls_resp_valid}, exp_grant_ls ? 2'b01 : 2'b10);
      exp_grant_ls = !exp_grant_ls;
    end
    bus.ls_req_valid = 1'b0;
    bus.if_req_valid = 1'b0;
    repeat (4) tick();
    check("rr_final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
